// File: rtl/pu_riscv_multiplier.sv
// Bit-serial RV M-extension multiplier (MUL/MULH/MULHSU/MULHU/MULW).
// Shift-add on operand magnitudes, one bit per cycle, sign fix-up on the final edge.
module pu_riscv_multiplier #(
    parameter int XLEN = 64,
    parameter int ILEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_stall,
    output logic            mul_stall,
    input  logic            id_bubble,
    input  logic [ILEN-1:0] id_instr,
    input  logic [XLEN-1:0] opA,
    input  logic [XLEN-1:0] opB,
    input  logic [1:0]      st_xlen,
    output logic            mul_bubble,
    output logic [XLEN-1:0] mul_r
);

    localparam logic [1:0]      RV32I     = 2'b01;
    localparam int              CNT_W     = $clog2(XLEN);
    localparam logic [6:0]      F7_MULDIV = 7'b0000001;
    localparam logic [4:0]      OPC_OP    = 5'b01100;
    localparam logic [4:0]      OPC_OP32  = 5'b01110;
    localparam logic [XLEN-1:0] LO32      = XLEN'(64'h0000_0000_FFFF_FFFF);
    localparam logic [XLEN-1:0] ONE       = XLEN'(1);

    // state  | meaning
    // ST_CHK | idle; decode, zero fast path, or set up an iteration run
    // ST_MUL | one shift-add step per cycle until cnt reaches zero
    // ST_RES | select/sign-correct the result and hand it to WB
    typedef enum logic [1:0] {ST_CHK, ST_MUL, ST_RES} state_t;
    typedef enum logic [2:0] {OP_NONE, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_MULW} op_t;

    function automatic op_t f_decode(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] opc, input logic rv64_ok);
        op_t op;
        op = OP_NONE;
        if (f7 == F7_MULDIV) begin
            if (opc == OPC_OP) begin
                case (f3)
                    3'b000:  op = OP_MUL;
                    3'b001:  op = OP_MULH;
                    3'b010:  op = OP_MULHSU;
                    3'b011:  op = OP_MULHU;
                    default: op = OP_NONE;
                endcase
            end else if (opc == OPC_OP32 && f3 == 3'b000 && rv64_ok) begin
                op = OP_MULW;
            end
        end
        return op;
    endfunction

    function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] x, input logic sgn);
        return (sgn && x[XLEN-1]) ? (~x + ONE) : x;
    endfunction

    state_t             r_state, w_nxt_state;
    logic               r_stall, w_nxt_stall;
    logic               r_bubble, w_nxt_bubble;
    logic [XLEN-1:0]    r_res, w_nxt_res;
    logic [XLEN-1:0]    r_a, w_nxt_a;
    logic [XLEN-1:0]    r_hi, w_nxt_hi;
    logic [XLEN-1:0]    r_lo, w_nxt_lo;
    logic               r_neg, w_nxt_neg;
    logic [CNT_W-1:0]   r_cnt, w_nxt_cnt;
    logic [6:0]         r_f7;
    logic [2:0]         r_f3;
    logic [4:0]         r_opc;

    op_t                w_op_id, w_op_lat;
    logic               w_sgn_a, w_sgn_b, w_zero;
    logic [XLEN-1:0]    w_opa, w_opb;
    logic [XLEN:0]      w_sum;
    logic [XLEN-1:0]    w_pn_hi;
    logic               w_unused_instr;

    assign w_unused_instr = ^id_instr;

    assign w_op_id  = f_decode(id_instr[31:25], id_instr[14:12], id_instr[6:2], st_xlen != RV32I);
    assign w_op_lat = f_decode(r_f7, r_f3, r_opc, 1'b1);

    // MULW works on the low words only, zero-extended
    assign w_opa   = (w_op_id == OP_MULW) ? (opA & LO32) : opA;
    assign w_opb   = (w_op_id == OP_MULW) ? (opB & LO32) : opB;
    assign w_sgn_a = (w_op_id == OP_MULH) || (w_op_id == OP_MULHSU);
    assign w_sgn_b = (w_op_id == OP_MULH);
    assign w_zero  = (w_opa == '0) || (w_opb == '0);

    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);

    // Upper half of -{hi,lo}: the +1 only carries into hi when lo is all zero
    assign w_pn_hi = r_neg ? (~r_hi + XLEN'(r_lo == '0)) : r_hi;

    always_comb begin
        w_nxt_state  = r_state;
        w_nxt_stall  = r_stall;
        w_nxt_bubble = 1'b1;
        w_nxt_res    = r_res;
        w_nxt_a      = r_a;
        w_nxt_hi     = r_hi;
        w_nxt_lo     = r_lo;
        w_nxt_neg    = r_neg;
        w_nxt_cnt    = r_cnt;
        case (r_state)
            ST_CHK: begin
                if (!ex_stall && !id_bubble && w_op_id != OP_NONE) begin
                    if (w_zero) begin
                        w_nxt_res    = '0;
                        w_nxt_bubble = 1'b0;
                    end else begin
                        w_nxt_state = ST_MUL;
                        w_nxt_stall = 1'b1;
                        w_nxt_a     = f_mag(w_opa, w_sgn_a);
                        w_nxt_lo    = f_mag(w_opb, w_sgn_b);
                        w_nxt_hi    = '0;
                        w_nxt_neg   = (w_sgn_a & w_opa[XLEN-1]) ^ (w_sgn_b & w_opb[XLEN-1]);
                        w_nxt_cnt   = (w_op_id == OP_MULW) ? CNT_W'(31) : CNT_W'(XLEN-1);
                    end
                end
            end
            ST_MUL: begin
                w_nxt_hi  = w_sum[XLEN:1];
                w_nxt_lo  = {w_sum[0], r_lo[XLEN-1:1]};
                w_nxt_cnt = r_cnt - CNT_W'(1);
                if (r_cnt == '0) begin
                    w_nxt_state = ST_RES;
                end
            end
            ST_RES: begin
                w_nxt_state  = ST_CHK;
                w_nxt_stall  = 1'b0;
                w_nxt_bubble = 1'b0;
                case (w_op_lat)
                    OP_MULH, OP_MULHSU: w_nxt_res = w_pn_hi;
                    OP_MULHU:           w_nxt_res = r_hi;
                    // after 32 steps the 32-bit product sits at the top of lo
                    OP_MULW:            w_nxt_res = XLEN'($signed(r_lo[XLEN-1 -: 32]));
                    default:            w_nxt_res = r_lo;
                endcase
            end
            default: begin
                w_nxt_state = ST_CHK;
                w_nxt_stall = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_CHK;
            r_stall  <= 1'b0;
            r_bubble <= 1'b1;
            r_res    <= '0;
            r_a      <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_f7     <= '0;
            r_f3     <= '0;
            r_opc    <= '0;
        end else begin
            r_state  <= w_nxt_state;
            r_stall  <= w_nxt_stall;
            r_bubble <= w_nxt_bubble;
            r_res    <= w_nxt_res;
            r_a      <= w_nxt_a;
            r_hi     <= w_nxt_hi;
            r_lo     <= w_nxt_lo;
            r_neg    <= w_nxt_neg;
            r_cnt    <= w_nxt_cnt;
            if (!ex_stall) begin
                r_f7  <= id_instr[31:25];
                r_f3  <= id_instr[14:12];
                r_opc <= id_instr[6:2];
            end
        end
    end

    assign mul_stall  = r_stall;
    assign mul_bubble = r_bubble;
    assign mul_r      = r_res;

endmodule

// File: tb/tb_pu_riscv_multiplier.sv
// Bench for pu_riscv_multiplier (XLEN=64): fixed vectors, reset abort, random ops vs a 128-bit model.
module tb_pu_riscv_multiplier;

    localparam int XLEN = 64;
    localparam int ILEN = 64;
    localparam int WIN  = 80;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_stall;
    logic            mul_stall;
    logic            id_bubble;
    logic [ILEN-1:0] id_instr;
    logic [XLEN-1:0] opA;
    logic [XLEN-1:0] opB;
    logic [1:0]      st_xlen;
    logic            mul_bubble;
    logic [XLEN-1:0] mul_r;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pu_riscv_multiplier #(.XLEN(XLEN), .ILEN(ILEN)) dut (
        .clk(clk), .rst(rst), .ex_stall(ex_stall), .mul_stall(mul_stall),
        .id_bubble(id_bubble), .id_instr(id_instr), .opA(opA), .opB(opB),
        .st_xlen(st_xlen), .mul_bubble(mul_bubble), .mul_r(mul_r)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] a;
        logic [63:0] b;
        logic [1:0]  xl;
        logic        idb;
        logic        exs;
        logic        acc;
        logic [63:0] exp_r;
        int          exp_edge;
    } vec_t;

    // op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW
    function automatic logic [31:0] enc(input logic [2:0] op);
        if (op == 3'd4) return {7'b0000001, 10'd0, 3'b000, 5'd0, 5'b01110, 2'b11};
        return {7'b0000001, 10'd0, op, 5'd0, 5'b01100, 2'b11};
    endfunction

    function automatic logic [63:0] ref_mul(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ua, ub, sa, sb, p;
        logic [31:0]  w;
        ua = {64'd0, a};
        ub = {64'd0, b};
        sa = {{64{a[63]}}, a};
        sb = {{64{b[63]}}, b};
        case (op)
            3'd0: begin p = ua * ub; return p[63:0]; end
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * ub; return p[127:64]; end
            3'd3: begin p = ua * ub; return p[127:64]; end
            default: begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
        endcase
    endfunction

    function automatic vec_t mk(input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b,
                                input logic [1:0] xl, input logic idb, input logic exs,
                                input logic acc, input logic [63:0] exp_r, input int exp_edge);
        vec_t v;
        v.instr = instr; v.a = a; v.b = b; v.xl = xl; v.idb = idb; v.exs = exs;
        v.acc = acc; v.exp_r = exp_r; v.exp_edge = exp_edge;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Present one instruction for the accept edge E0, then watch WIN edges.
    // res_edge = index of the first edge after which mul_bubble was low (-1: none).
    task automatic run_op(input logic [31:0] instr, input logic [63:0] a, input logic [63:0] b,
                          input logic [1:0] xl, input logic idb, input logic exs,
                          output logic [63:0] res, output int stall_cyc,
                          output int res_edge, output int bub_lows);
        @(negedge clk);
        id_instr  = {32'hA5A5_0F0F, instr};
        opA       = a;
        opB       = b;
        st_xlen   = xl;
        id_bubble = idb;
        ex_stall  = exs;
        @(posedge clk);
        #1 id_bubble = 1'b1;
        res = '0; stall_cyc = 0; res_edge = -1; bub_lows = 0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            if (mul_stall) stall_cyc++;
            if (!mul_bubble) begin
                bub_lows++;
                if (res_edge < 0) begin
                    res_edge = k;
                    res = mul_r;
                end
            end
        end
        ex_stall = 1'b0;
    endtask

    task automatic check_run(input string nm, input logic acc, input logic [63:0] exp_r,
                             input int exp_edge, input logic [63:0] res, input int stall_cyc,
                             input int res_edge, input int bub_lows);
        chk({nm, "_bubble_lows"}, 64'(bub_lows), acc ? 64'd1 : 64'd0);
        chk({nm, "_stall_cycles"}, 64'(stall_cyc), 64'((exp_edge > 0) ? exp_edge : 0));
        chk({nm, "_result_edge"}, 64'(res_edge), 64'(exp_edge));
        if (acc) chk({nm, "_result"}, res, exp_r);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vt[14];
        logic [63:0] res;
        int          sc, re, bl;
        logic [2:0]  op;
        logic [63:0] a, b, er;
        logic        zero;
        int          n;

        rst = 1'b1; ex_stall = 1'b0; id_bubble = 1'b1; id_instr = '0;
        opA = '0; opB = '0; st_xlen = 2'b10;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 64'(mul_stall), 64'd0);
        chk("reset_bubble", 64'(mul_bubble), 64'd1);
        chk("reset_r", mul_r, 64'd0);
        rst = 1'b0;

        vt[0]  = mk(enc(0), 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 2'b10, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFEB, 65);
        vt[1]  = mk(enc(3), '1, '1, 2'b10, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
        vt[2]  = mk(enc(1), '1, '1, 2'b10, 0, 0, 1, 64'h0, 65);
        vt[3]  = mk(enc(2), '1, 64'd2, 2'b10, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        vt[4]  = mk(enc(1), 64'h8000_0000_0000_0000, 64'd2, 2'b10, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 65);
        vt[5]  = mk(enc(4), 64'h1234_5678_7FFF_FFFF, 64'd2, 2'b10, 0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
        vt[6]  = mk(enc(4), 64'h1234_5678_7FFF_FFFF, 64'd2, 2'b01, 0, 0, 0, 64'h0, -1);
        vt[7]  = mk(enc(0), 64'd0, 64'd5, 2'b10, 0, 0, 1, 64'h0, 0);
        vt[8]  = mk(enc(0), 64'd3, 64'd4, 2'b10, 1, 0, 0, 64'h0, -1);
        vt[9]  = mk(enc(0), 64'd3, 64'd4, 2'b10, 0, 1, 0, 64'h0, -1);
        vt[10] = mk(enc(3), 64'd9, 64'd9, 2'b10, 0, 0, 1, 64'd0, 65);
        vt[11] = mk(enc(4), 64'hFFFF_FFFF_0000_0000, 64'd3, 2'b10, 0, 0, 1, 64'h0, 0);
        vt[12] = mk({7'b0000000, 10'd0, 3'b000, 5'd0, 5'b01100, 2'b11}, 64'd3, 64'd4, 2'b10, 0, 0, 0, 64'h0, -1);
        vt[13] = mk({7'b0000001, 10'd0, 3'b100, 5'd0, 5'b01100, 2'b11}, 64'd3, 64'd4, 2'b10, 0, 0, 0, 64'h0, -1);

        for (int i = 0; i < 14; i++) begin
            run_op(vt[i].instr, vt[i].a, vt[i].b, vt[i].xl, vt[i].idb, vt[i].exs, res, sc, re, bl);
            check_run($sformatf("vec%0d", i), vt[i].acc, vt[i].exp_r, vt[i].exp_edge, res, sc, re, bl);
        end

        // Abort a MULHU mid-iteration with an asynchronous reset.
        run_op(enc(0), 64'd6, 64'd7, 2'b10, 0, 0, res, sc, re, bl);
        check_run("pre_reset_mul", 1'b1, 64'd42, 65, res, sc, re, bl);
        @(negedge clk);
        id_instr = {32'h0, enc(3)}; opA = '1; opB = '1; st_xlen = 2'b10; id_bubble = 1'b0;
        @(posedge clk);
        #1 id_bubble = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        chk("mid_op_stall", 64'(mul_stall), 64'd1);
        rst = 1'b1;
        #1;
        chk("abort_stall", 64'(mul_stall), 64'd0);
        chk("abort_bubble", 64'(mul_bubble), 64'd1);
        chk("abort_r", mul_r, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bl = 0; sc = 0;
        for (int k = 0; k < WIN; k++) begin
            @(negedge clk);
            if (!mul_bubble) bl++;
            if (mul_stall) sc++;
        end
        chk("abort_no_result", 64'(bl), 64'd0);
        chk("abort_no_stall", 64'(sc), 64'd0);
        run_op(enc(0), 64'd3, 64'd4, 2'b10, 0, 0, res, sc, re, bl);
        check_run("post_reset_mul", 1'b1, 64'd12, 65, res, sc, re, bl);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 4));
            a  = {$urandom, $urandom};
            b  = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: a = '0;
                1: b = (op == 3'd4) ? {$urandom, 32'h0} : 64'h0;
                2: a = 64'h8000_0000_0000_0000;
                3: b = '1;
                default: ;
            endcase
            er   = ref_mul(op, a, b);
            zero = (op == 3'd4) ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0);
            n    = (op == 3'd4) ? 32 : 64;
            run_op(enc(op), a, b, 2'b10, 0, 0, res, sc, re, bl);
            check_run($sformatf("rand%0d_op%0d", i, op), 1'b1, er, zero ? 0 : n + 1, res, sc, re, bl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pu_riscv_multiplier.md
Name: pu_riscv_multiplier

Overview:
- Bit-serial RV M-extension multiply unit in the execute stage: MUL, MULH, MULHSU, MULHU, MULW.
- Sits beside the divide unit and shares its interface style: operands and instruction come from ID/EX, the pipeline is stalled while iterating, and a registered result goes to WB tagged with a bubble flag.
- Uses a shift-add algorithm on operand magnitudes, with sign correction at the end.

Parameters:
- XLEN, 64, datapath width (32 or 64).
- ILEN, 64, instruction register width; only bits [31:0] are decoded.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ex_stall  in  1  execute stage stalled; no new instruction is accepted while high.
- mul_stall  out  1  high while a multiply is iterating.
- id_bubble  in  1  id_instr is invalid.
- id_instr  in  ILEN  instruction; decode uses func7=[31:25], func3=[14:12], opcode=[6:2].
- opA  in  XLEN  rs1 operand.
- opB  in  XLEN  rs2 operand.
- st_xlen  in  2  current XLEN mode; equal to RV32I means 32-bit mode.
- mul_bubble  out  1  low for exactly one cycle when mul_r holds a valid result.
- mul_r  out  XLEN  result to WB.

Behaviour:
- Reset (async, rst=1):
  - state=ST_CHK, mul_bubble=1, mul_stall=0, mul_r=0.
  - All internal registers cleared.
  - Reset mid-operation aborts the multiply; no result is produced.
- Decode (func7=0000001):
  - opcode 01100, func3 000/001/010/011 = MUL/MULH/MULHSU/MULHU.
  - opcode 01110, func3 000 = MULW, legal only when not in 32-bit mode.
  - Anything else: no action; mul_bubble stays 1.
- Instruction is latched whenever ex_stall=0. The latched copy selects the result in ST_RES.
- mul_bubble defaults to 1 on every cycle unless a result is driven that cycle.
- ST_CHK: acts only when ex_stall=0 and id_bubble=0 and the instruction decodes.
  - Zero fast path: if the relevant operands are zero (full width; low 32 bits for MULW), the next edge drives mul_r=0 and mul_bubble=0. No stall, state unchanged.
  - Otherwise, set up and go to ST_MUL with mul_stall=1:
    - MUL, MULHU: both operands taken unsigned.
    - MULH: both operands signed.
    - MULHSU: opA signed, opB unsigned.
    - MULW: opA[31:0] and opB[31:0] zero-extended.
    - Load a = |opA| and lo = |opB|, where |x| is the magnitude for a signed operand and the raw value for an unsigned one. Clear hi and carry.
    - neg = sign(opA) XOR sign(opB), counting only signed operands.
    - Iteration count N = XLEN (MULW: 32); cnt = N-1.
- ST_MUL: one iteration per cycle.
  - {c,hi} = hi + (lo[0] ? a : 0), computed at XLEN+1 bits.
  - {hi,lo} = {c,hi,lo} >> 1.
  - cnt decrements; at cnt==0 go to ST_RES.
  - ex_stall is ignored during ST_MUL.
- ST_RES: on its edge, mul_bubble=0, mul_stall=0, state=ST_CHK.
  - Let P = {hi,lo}, a 2*XLEN-bit value; Pn = neg ? (~P+1) : P.
  - MUL: lo (signedness is irrelevant for the low half).
  - MULH, MULHSU: Pn[2XLEN-1:XLEN].
  - MULHU: hi.
  - MULW: sign-extend lo[XLEN-1:XLEN-32] to XLEN.
- Latency: with the accept edge as E0, iterations occur on E1..EN and the result is registered on EN+1.
  - mul_stall is high from E0 to EN+1 (N+1 cycles).
  - mul_r holds until the next result.
- No new instruction is accepted in ST_MUL or ST_RES.
- A result cycle and an accept never coincide, because acceptance happens only in ST_CHK.

Test Plan (XLEN=64):
- MUL opA=7, opB=0xFFFF_FFFF_FFFF_FFFD -> mul_r=0xFFFF_FFFF_FFFF_FFEB; mul_stall high 65 cycles; mul_bubble low exactly 1 cycle, 65 edges after accept.
- MULHU opA=opB=0xFFFF_FFFF_FFFF_FFFF -> 0xFFFF_FFFF_FFFF_FFFE. MULH with the same operands (-1*-1) -> 0x0.
- MULHSU opA=0xFFFF_FFFF_FFFF_FFFF (-1), opB=2 -> 0xFFFF_FFFF_FFFF_FFFF. MULH opA=0x8000_0000_0000_0000, opB=2 -> 0xFFFF_FFFF_FFFF_FFFF.
- MULW opA=0x1234_5678_7FFF_FFFF, opB=2 -> 0xFFFF_FFFF_FFFF_FFFE; stall 33 cycles. Same instruction with st_xlen=RV32I -> ignored, mul_bubble stays 1, no stall.
- Fast path: MUL opA=0, opB=5 -> mul_r=0 with mul_bubble=0 on the edge after accept, mul_stall never asserts. An instruction with id_bubble=1 or ex_stall=1 -> ignored.
- Reset: assert rst 10 cycles into a MULHU -> immediately mul_stall=0, mul_bubble=1, mul_r=0. A following MUL 3*4 -> 12 with normal latency.
